datard: RTL

Packet read-out engine for the SRAM controller, the read-side counterpart of the packet write path. It accepts one read command at a time (start address, length in words, destination port) and issues consecutive SRAM reads. It absorbs the fixed SRAM read latency in a small credit-controlled FIFO and streams the packet to the output port with valid/ready handshaking and sop/eop framing. It sits between the queue scheduler, which supplies commands, and the SRAM read port and egress logic.

---
 rtl/datard.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/datard.sv
// Packet read-out engine: turns one read command into consecutive SRAM reads.
// The fixed read latency is absorbed in a credit-controlled FIFO that streams sop/eop-framed words.
module datard #(
    parameter int rd_data_width        = 64,
    parameter int rd_address_width     = 17,
    parameter int rd_des_width         = 4,
    parameter int rd_pack_length_width = 8,
    parameter int rd_latency           = 2,
    parameter int fifo_depth           = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [rd_address_width-1:0]     cmd_address,
    input  logic [rd_pack_length_width-1:0] cmd_length,
    input  logic [rd_des_width-1:0]         cmd_des_port,
    output logic                            sram_rd_en,
    output logic [rd_address_width-1:0]     sram_rd_addr,
    input  logic [rd_data_width-1:0]        sram_rd_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [rd_data_width-1:0]        out_data,
    output logic                            out_sop,
    output logic                            out_eop,
    output logic [rd_des_width-1:0]         out_des_port,
    output logic                            busy
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    typedef struct packed {
        logic valid;
        logic sop;
        logic eop;
    } tag_t;

    localparam int ptr_width = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int cnt_width = $clog2(fifo_depth + 1);
    localparam int sum_width = $clog2(fifo_depth + rd_latency + 1);

    state_t                          state, next_state;
    logic [rd_address_width-1:0]     addr;
    logic [rd_pack_length_width-1:0] remaining;
    logic [rd_des_width-1:0]         des_port;
    logic                            sop_pending;

    tag_t                            pipe [rd_latency];
    logic [rd_data_width-1:0]        fifo_data [fifo_depth];
    logic                            fifo_sop  [fifo_depth];
    logic                            fifo_eop  [fifo_depth];
    logic [ptr_width-1:0]            wr_ptr, rd_ptr;
    logic [cnt_width-1:0]            fifo_count;

    logic [sum_width-1:0]            inflight;
    logic                            credit;
    logic                            accept;
    logic                            issue;
    logic                            last_issue;
    logic                            push;
    logic                            pop;

    function automatic logic [ptr_width-1:0] ptr_inc(input logic [ptr_width-1:0] p);
        return (p == ptr_width'(fifo_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit uses registered counts only, so a pop in this cycle frees nothing until the next one.
    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < rd_latency; i++) begin
            inflight = inflight + sum_width'(pipe[i].valid);
        end
    end

    assign credit     = (sum_width'(fifo_count) + inflight) < sum_width'(fifo_depth);
    assign accept     = cmd_valid && cmd_ready;
    assign issue      = sram_rd_en;
    assign last_issue = issue && (remaining == rd_pack_length_width'(1));
    assign push       = pipe[rd_latency-1].valid;
    assign pop        = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_valid && (cmd_length != '0)) next_state = READ;
            READ:    if (last_issue) next_state = DRAIN;
            DRAIN:   if (pop && out_eop) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state == IDLE);
        busy       = (state != IDLE);
        sram_rd_en = (state == READ) && credit;
    end

    // A zero-length command is latched like any other but never leaves IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr        <= '0;
            remaining   <= '0;
            des_port    <= '0;
            sop_pending <= 1'b0;
        end else if (accept) begin
            addr        <= cmd_address;
            remaining   <= cmd_length;
            des_port    <= cmd_des_port;
            sop_pending <= 1'b1;
        end else if (issue) begin
            addr        <= addr + 1'b1;
            remaining   <= remaining - 1'b1;
            sop_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < rd_latency; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: issue, sop: issue && sop_pending, eop: last_issue};
            for (int i = 1; i < rd_latency; i++) pipe[i] <= pipe[i-1];
        end
    end

    // NOTE: FIFO storage has no reset; only pointers and count are cleared, and the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= sram_rd_data;
            fifo_sop[wr_ptr]  <= pipe[rd_latency-1].sop;
            fifo_eop[wr_ptr]  <= pipe[rd_latency-1].eop;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign out_valid    = (fifo_count != '0);
    assign out_data     = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_sop      = out_valid && fifo_sop[rd_ptr];
    assign out_eop      = out_valid && fifo_eop[rd_ptr];
    assign out_des_port = des_port;
    assign sram_rd_addr = addr;

endmodule
